// File: rtl/score_ssd_if.sv
// score_ssd_if: grow/clear inputs and score/SSD outputs of the score display driver.
interface score_ssd_if;
  logic        grow;
  logic        clr;
  logic [15:0] score_bcd;
  logic [7:0]  An;
  logic [7:0]  Cathodes;
  modport master (output grow, clr, input score_bcd, An, Cathodes);
  modport slave (input grow, clr, output score_bcd, An, Cathodes);
endinterface

// File: rtl/score_ssd_driver.sv
// score_ssd_driver: 4-digit BCD score counter driving a time-multiplexed seven-segment display.
// Define SCORE_BLANK_EN to blank leading zeros on the upper three digits.
module score_ssd_driver #(
  parameter int          SCAN_BIT  = 18,
  parameter logic [15:0] SAT_SCORE = 16'h9999
) (
  input logic        ClkPort,
  input logic        Reset,
  score_ssd_if.slave bus
);
  logic [2:0]          sync_q, sync_d;
  logic [15:0]         score_q, score_d, score_inc;
  logic [SCAN_BIT+1:0] cnt_q, cnt_d;
  logic [7:0]          an_q, an_d, cat_q, cat_d;
  logic [1:0]          sel;
  logic [3:0]          digit;
  logic                inc, carry, blank;

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'b0000_0011;
      4'd1:    seg = 8'b1001_1111;
      4'd2:    seg = 8'b0010_0101;
      4'd3:    seg = 8'b0000_1101;
      4'd4:    seg = 8'b1001_1001;
      4'd5:    seg = 8'b0100_1001;
      4'd6:    seg = 8'b0100_0001;
      4'd7:    seg = 8'b0001_1111;
      4'd8:    seg = 8'b0000_0001;
      4'd9:    seg = 8'b0000_1001;
      default: seg = 8'hFF;
    endcase
  endfunction

  always_comb begin
    sync_d    = {sync_q[1:0], bus.grow};
    inc       = sync_q[1] & ~sync_q[2];
    score_inc = score_q;
    carry     = 1'b1;
    // Ripple carry: a digit advances only while every lower digit is rolling over from 9.
    for (int i = 0; i < 4; i++) begin
      score_inc[4*i +: 4] = carry ? ((score_q[4*i +: 4] == 4'd9) ? 4'd0 : score_q[4*i +: 4] + 4'd1)
                                  : score_q[4*i +: 4];
      carry = carry & (score_q[4*i +: 4] == 4'd9);
    end
    score_d = bus.clr ? 16'h0000 : (inc && score_q != SAT_SCORE) ? score_inc : score_q;
    cnt_d   = cnt_q + 1'b1;
    sel     = cnt_q[SCAN_BIT+1 -: 2];
    digit   = score_q[{sel, 2'b00} +: 4];
`ifdef SCORE_BLANK_EN
    blank = (sel == 2'd3) ? (score_q[15:12] == 4'd0) :
            (sel == 2'd2) ? (score_q[15:8] == 8'd0) :
            (sel == 2'd1) ? (score_q[15:4] == 12'd0) : 1'b0;
`else
    blank = 1'b0;
`endif
    an_d  = ~(8'h01 << sel);
    cat_d = blank ? 8'hFF : seg(digit);
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '0;
      score_q <= '0;
      cnt_q   <= '0;
      an_q    <= 8'hFE;
      cat_q   <= 8'h03;
    end else begin
      sync_q  <= sync_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      cat_q   <= cat_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.An        = an_q;
  assign bus.Cathodes  = cat_q;
endmodule
